// File: rtl/multicycle_control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// riscv_ctrl_pkg
//   Shared constants for the multicycle RV32 controller: opcodes, ULA operation
//   codes, mux-select encodings for the datapath and the controller state enum.
//   No ports (package).
// -----------------------------------------------------------------------------
package riscv_ctrl_pkg;

  // Opcodes (IR[6:0]) the controller understands
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Funct7 values distinguishing R-type add from sub
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ULAControl codes
  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_AND = 3'b010;
  localparam logic [2:0] ULA_OR  = 3'b011;
  localparam logic [2:0] ULA_SLT = 3'b101;
  localparam logic [2:0] ULA_XOR = 3'b111;

  // ImmSrc encodings
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ULA    = 2'b10;

  // ULASrcA encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  // ULASrcB encodings
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXER,
    S_EXEI,
    S_ALUWB,
    S_BEQ,
    S_HALT
  } state_e;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm_if
//   Bundle between the control FSM and the datapath/memory.
//   master : the controller (takes instruction fields/flags, drives controls)
//   slave  : the datapath side (drives instruction fields/flags, takes controls)
//   Signals: OP, Funct3, Funct7, Zero, mem_ready   (datapath -> controller)
//            mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc,
//            ULASrcA, ULASrcB, ULAControl, ImmSrc, illegal, instr_retired
//                                                  (controller -> datapath)
// -----------------------------------------------------------------------------
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       OP;
  logic [2:0]       Funct3;
  logic [6:0]       Funct7;
  logic             Zero;
  logic             mem_ready;
  logic             mem_req;
  logic             MemWrite;
  logic             AdrSrc;
  logic             IRWrite;
  logic             PCWrite;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ULASrcA;
  logic [1:0]       ULASrcB;
  logic [2:0]       ULAControl;
  logic [1:0]       ImmSrc;
  logic             illegal;
  logic [CNT_W-1:0] instr_retired;

  modport master (
    input  OP, Funct3, Funct7, Zero, mem_ready,
    output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc,
           ULASrcA, ULASrcB, ULAControl, ImmSrc, illegal, instr_retired
  );

  modport slave (
    output OP, Funct3, Funct7, Zero, mem_ready,
    input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc,
           ULASrcA, ULASrcB, ULAControl, ImmSrc, illegal, instr_retired
  );
endinterface

// File: rtl/multicycle_control_fsm_ula_decoder.sv
// -----------------------------------------------------------------------------
// ula_decoder
//   Combinational instruction classifier: maps {OP, Funct3, Funct7} to the ULA
//   operation used in the execute state and flags whether the instruction is in
//   the supported set.
//   Ports: op_i[6:0], funct3_i[2:0], funct7_i[6:0] -> ula_ctrl_o[2:0], legal_o
// -----------------------------------------------------------------------------
module ula_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [2:0] ula_ctrl_o,
  output logic       legal_o
);

  always_comb begin
    ula_ctrl_o = ULA_ADD;
    legal_o    = 1'b0;
    case (op_i)
      // lb/lw and sb/sw share the same control; byte select is in the memory
      OP_LOAD, OP_STORE: begin
        legal_o = (funct3_i == 3'b000) || (funct3_i == 3'b010);
      end
      OP_RTYPE: begin
        if (funct7_i == F7_BASE) begin
          legal_o = 1'b1;
          case (funct3_i)
            3'b000:  ula_ctrl_o = ULA_ADD;
            3'b111:  ula_ctrl_o = ULA_AND;
            3'b110:  ula_ctrl_o = ULA_OR;
            3'b100:  ula_ctrl_o = ULA_XOR;
            3'b010:  ula_ctrl_o = ULA_SLT;
            default: legal_o    = 1'b0;
          endcase
        end else if ((funct7_i == F7_ALT) && (funct3_i == 3'b000)) begin
          legal_o    = 1'b1;
          ula_ctrl_o = ULA_SUB;
        end
      end
      OP_ITYPE: begin
        legal_o = 1'b1;
        case (funct3_i)
          3'b000:  ula_ctrl_o = ULA_ADD;
          3'b110:  ula_ctrl_o = ULA_OR;
          3'b111:  ula_ctrl_o = ULA_AND;
          default: legal_o    = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        legal_o    = (funct3_i == 3'b000);
        ula_ctrl_o = ULA_SUB;
      end
      default: begin
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//   Moore sequencing controller for the multicycle RV32 datapath. Steps each
//   instruction through fetch/decode/execute/writeback states and drives the
//   ULA, register file, PC and shared-memory controls. Unsupported
//   instructions park the core in S_HALT with a sticky illegal flag.
//   Parameters: MEM_WAIT_EN (1: memory states wait on mem_ready, 0: one cycle),
//               CNT_W (retired-instruction counter width)
//   Ports: clk, rst_n (async active-low), bus (multicycle_control_fsm_if.master)
// -----------------------------------------------------------------------------
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_fsm_if.master  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  logic       ready_eff;
  logic [2:0] dec_ula;
  logic       dec_legal;

  logic       mem_req, mem_write, adr_src, ir_write, reg_write;
  logic       pc_update, branch, retire;
  logic [1:0] result_src, src_a, src_b, imm_src;
  logic [2:0] ula_ctrl;

  // With waiting disabled every memory access completes in its first cycle
  assign ready_eff = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  ula_decoder u_ula_decoder (
    .op_i       (bus.OP),
    .funct3_i   (bus.Funct3),
    .funct7_i   (bus.Funct7),
    .ula_ctrl_o (dec_ula),
    .legal_o    (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_HALT) begin
        illegal_q <= 1'b1;
      end
      if (retire) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    retire     = 1'b0;
    result_src = RES_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_B;
    ula_ctrl   = ULA_ADD;
    imm_src    = IMM_I;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        // PC+4 computed in the ULA and written straight back as the IR loads
        mem_req    = 1'b1;
        src_b      = SRCB_FOUR;
        result_src = RES_ULA;
        ir_write   = ready_eff;
        pc_update  = ready_eff;
        if (ready_eff) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut
        src_a   = SRCA_OLDPC;
        src_b   = SRCB_IMM;
        imm_src = IMM_B;
        if (!dec_legal) begin
          state_d = S_HALT;
        end else begin
          case (bus.OP)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_RTYPE:          state_d = S_EXER;
            OP_ITYPE:          state_d = S_EXEI;
            OP_BRANCH:         state_d = S_BEQ;
            default:           state_d = S_HALT;
          endcase
        end
      end
      S_MEMADR: begin
        src_a   = SRCA_A;
        src_b   = SRCB_IMM;
        imm_src = (bus.OP == OP_STORE) ? IMM_S : IMM_I;
        state_d = (bus.OP == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (ready_eff) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (ready_eff) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXER: begin
        src_a    = SRCA_A;
        src_b    = SRCB_B;
        ula_ctrl = dec_ula;
        state_d  = S_ALUWB;
      end
      S_EXEI: begin
        src_a    = SRCA_A;
        src_b    = SRCB_IMM;
        imm_src  = IMM_I;
        ula_ctrl = dec_ula;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        src_a    = SRCA_A;
        src_b    = SRCB_B;
        ula_ctrl = ULA_SUB;
        branch   = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.mem_req       = mem_req;
  assign bus.MemWrite      = mem_write;
  assign bus.AdrSrc        = adr_src;
  assign bus.IRWrite       = ir_write;
  assign bus.PCWrite       = pc_update | (branch & bus.Zero);
  assign bus.RegWrite      = reg_write;
  assign bus.ResultSrc     = result_src;
  assign bus.ULASrcA       = src_a;
  assign bus.ULASrcB       = src_b;
  assign bus.ULAControl    = ula_ctrl;
  assign bus.ImmSrc        = imm_src;
  assign bus.illegal       = illegal_q;
  assign bus.instr_retired = cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//   Directed bench for multicycle_control_fsm. The main instance waits on
//   mem_ready with a 32-bit counter; a second instance (no memory wait, 2-bit
//   counter) exercises the ready-ignored mode and counter wrap.
//   Control outputs are compared as one 17-bit vector:
//   {mem_req,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ResultSrc,ULASrcA,
//    ULASrcB,ULAControl,ImmSrc}
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;

  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.CNT_W(32)) bus ();
  multicycle_control_fsm_if #(.CNT_W(2))  bus2 ();

  multicycle_control_fsm #(.MEM_WAIT_EN(1'b1), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  multicycle_control_fsm #(.MEM_WAIT_EN(1'b0), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  // Hand-encoded per-state control vectors
  localparam logic [16:0] V_ZERO     = 17'b0_0_0_0_0_0_00_00_00_000_00;
  localparam logic [16:0] V_FETCH_R  = 17'b1_0_0_1_1_0_10_00_10_000_00;
  localparam logic [16:0] V_FETCH_W  = 17'b1_0_0_0_0_0_10_00_10_000_00;
  localparam logic [16:0] V_DECODE   = 17'b0_0_0_0_0_0_00_01_01_000_10;
  localparam logic [16:0] V_ALUWB    = 17'b0_0_0_0_0_1_00_00_00_000_00;
  localparam logic [16:0] V_MEMADR_L = 17'b0_0_0_0_0_0_00_10_01_000_00;
  localparam logic [16:0] V_MEMADR_S = 17'b0_0_0_0_0_0_00_10_01_000_01;
  localparam logic [16:0] V_MEMRD    = 17'b1_0_1_0_0_0_00_00_00_000_00;
  localparam logic [16:0] V_MEMWB    = 17'b0_0_0_0_0_1_01_00_00_000_00;
  localparam logic [16:0] V_MEMWR    = 17'b1_1_1_0_0_0_00_00_00_000_00;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  function automatic logic [16:0] ctl_vec();
    return {bus.mem_req, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite,
            bus.RegWrite, bus.ResultSrc, bus.ULASrcA, bus.ULASrcB,
            bus.ULAControl, bus.ImmSrc};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    bus.OP = 7'd0; bus.Funct3 = 3'd0; bus.Funct7 = 7'd0;
    bus.Zero = 1'b0; bus.mem_ready = 1'b1;
    bus2.OP = 7'd0; bus2.Funct3 = 3'd0; bus2.Funct7 = 7'd0;
    bus2.Zero = 1'b0; bus2.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ctl_vec() !== V_ZERO) begin
      errors++; $display("FAIL reset_ctl: got %b expected %b", ctl_vec(), V_ZERO);
    end
    checks++;
    if (bus.instr_retired !== 32'd0 || bus.illegal !== 1'b0) begin
      errors++; $display("FAIL reset_regs: got cnt=%0d ill=%b expected cnt=0 ill=0",
                         bus.instr_retired, bus.illegal);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ctl_vec() !== V_ZERO) begin
      errors++; $display("FAIL reset_idle: got %b expected %b", ctl_vec(), V_ZERO);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ctl_vec() !== V_FETCH_R) begin
      errors++; $display("FAIL reset_fetch: got %b expected %b", ctl_vec(), V_FETCH_R);
    end
    $display("reset: idle one cycle then fetch, retired=%0d", bus.instr_retired);
  endtask

  // Entered at a negedge with the FSM in S_FETCH; leaves it in S_FETCH
  task automatic test_rtype(input logic [2:0] f3, input logic [6:0] f7,
                            input logic [2:0] ula, input string name);
    logic [16:0] exp_v [4];
    exp_v[0] = V_FETCH_R;
    exp_v[1] = V_DECODE;
    exp_v[2] = {6'b000000, 2'b00, 2'b10, 2'b00, ula, 2'b00};
    exp_v[3] = V_ALUWB;
    bus.OP = 7'b0110011; bus.Funct3 = f3; bus.Funct7 = f7; bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctl_vec() !== exp_v[i]) begin
        errors++; $display("FAIL %s_step%0d: got %b expected %b", name, i, ctl_vec(), exp_v[i]);
      end
      checks++;
      if (bus.instr_retired !== exp_cnt) begin
        errors++; $display("FAIL %s_cnt%0d: got %0d expected %0d", name, i, bus.instr_retired, exp_cnt);
      end
      @(negedge clk);
    end
    exp_cnt++;
    #1;
    checks++;
    if (ctl_vec() !== V_FETCH_R || bus.instr_retired !== exp_cnt) begin
      errors++; $display("FAIL %s_retire: got %b cnt=%0d expected %b cnt=%0d",
                         name, ctl_vec(), bus.instr_retired, V_FETCH_R, exp_cnt);
    end
    $display("%s: 4 cycles, ULAControl=%b, retired=%0d", name, ula, bus.instr_retired);
  endtask

  task automatic test_itype_ori;
    logic [16:0] exp_v [4];
    exp_v[0] = V_FETCH_R;
    exp_v[1] = V_DECODE;
    exp_v[2] = 17'b0_0_0_0_0_0_00_10_01_011_00;
    exp_v[3] = V_ALUWB;
    bus.OP = 7'b0010011; bus.Funct3 = 3'b110; bus.Funct7 = 7'b1010101; bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctl_vec() !== exp_v[i]) begin
        errors++; $display("FAIL ori_step%0d: got %b expected %b", i, ctl_vec(), exp_v[i]);
      end
      @(negedge clk);
    end
    exp_cnt++;
    #1;
    checks++;
    if (ctl_vec() !== V_FETCH_R || bus.instr_retired !== exp_cnt) begin
      errors++; $display("FAIL ori_retire: got %b cnt=%0d expected %b cnt=%0d",
                         ctl_vec(), bus.instr_retired, V_FETCH_R, exp_cnt);
    end
    $display("ori: 4 cycles via S_EXEI, retired=%0d", bus.instr_retired);
  endtask

  // lw with mem_ready low in decode/memadr (ignored) and 3 cycles in S_MEMRD
  task automatic test_load_wait;
    logic [16:0] exp_v [8];
    logic        rdy   [8];
    exp_v = '{V_FETCH_R, V_DECODE, V_MEMADR_L, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB};
    rdy   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.OP = 7'b0000011; bus.Funct3 = 3'b010; bus.Funct7 = 7'd0;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      checks++;
      if (ctl_vec() !== exp_v[i]) begin
        errors++; $display("FAIL lw_step%0d: got %b expected %b", i, ctl_vec(), exp_v[i]);
      end
      if (i == 7) begin
        checks++;
        if (bus.instr_retired !== exp_cnt) begin
          errors++; $display("FAIL lw_cnt_wb: got %0d expected %0d", bus.instr_retired, exp_cnt);
        end
      end
      @(negedge clk);
    end
    bus.mem_ready = 1'b1;
    exp_cnt++;
    #1;
    checks++;
    if (ctl_vec() !== V_FETCH_R || bus.instr_retired !== exp_cnt) begin
      errors++; $display("FAIL lw_retire: got %b cnt=%0d expected %b cnt=%0d",
                         ctl_vec(), bus.instr_retired, V_FETCH_R, exp_cnt);
    end
    $display("lw: 8 cycles with 3 wait states, retired=%0d", bus.instr_retired);
  endtask

  // sw with one fetch stall and one write stall
  task automatic test_store_wait;
    logic [16:0] exp_v [6];
    logic        rdy   [6];
    exp_v = '{V_FETCH_W, V_FETCH_R, V_DECODE, V_MEMADR_S, V_MEMWR, V_MEMWR};
    rdy   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.OP = 7'b0100011; bus.Funct3 = 3'b000; bus.Funct7 = 7'd0;
    for (int i = 0; i < 6; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      checks++;
      if (ctl_vec() !== exp_v[i] || bus.instr_retired !== exp_cnt) begin
        errors++; $display("FAIL sw_step%0d: got %b cnt=%0d expected %b cnt=%0d",
                           i, ctl_vec(), bus.instr_retired, exp_v[i], exp_cnt);
      end
      @(negedge clk);
    end
    exp_cnt++;
    #1;
    checks++;
    if (ctl_vec() !== V_FETCH_R || bus.instr_retired !== exp_cnt) begin
      errors++; $display("FAIL sw_retire: got %b cnt=%0d expected %b cnt=%0d",
                         ctl_vec(), bus.instr_retired, V_FETCH_R, exp_cnt);
    end
    $display("sb: 6 cycles with fetch and write stalls, retired=%0d", bus.instr_retired);
  endtask

  task automatic test_beq(input logic z);
    logic [16:0] exp_v [3];
    exp_v[0] = V_FETCH_R;
    exp_v[1] = V_DECODE;
    exp_v[2] = {4'b0000, z, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00};
    bus.OP = 7'b1100011; bus.Funct3 = 3'b000; bus.Funct7 = 7'd0;
    bus.Zero = z; bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl_vec() !== exp_v[i]) begin
        errors++; $display("FAIL beq_z%0b_step%0d: got %b expected %b", z, i, ctl_vec(), exp_v[i]);
      end
      @(negedge clk);
    end
    bus.Zero = 1'b0;
    exp_cnt++;
    #1;
    checks++;
    if (ctl_vec() !== V_FETCH_R || bus.instr_retired !== exp_cnt) begin
      errors++; $display("FAIL beq_z%0b_retire: got %b cnt=%0d expected %b cnt=%0d",
                         z, ctl_vec(), bus.instr_retired, V_FETCH_R, exp_cnt);
    end
    $display("beq Zero=%0b: 3 cycles, retired=%0d", z, bus.instr_retired);
  endtask

  task automatic test_reset_midwrite;
    bus.OP = 7'b0100011; bus.Funct3 = 3'b010; bus.Funct7 = 7'd0; bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);        // FETCH -> DECODE -> MEMADR
    bus.mem_ready = 1'b0;
    @(negedge clk);                   // stalled in MEMWR
    #1;
    checks++;
    if (ctl_vec() !== V_MEMWR) begin
      errors++; $display("FAIL rstmw_inwrite: got %b expected %b", ctl_vec(), V_MEMWR);
    end
    #2;
    rst_n = 1'b0;
    exp_cnt = 32'd0;
    #1;
    checks++;
    if (ctl_vec() !== V_ZERO || bus.instr_retired !== exp_cnt || bus.illegal !== 1'b0) begin
      errors++; $display("FAIL rstmw_drop: got %b cnt=%0d expected %b cnt=0",
                         ctl_vec(), bus.instr_retired, V_ZERO);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ctl_vec() !== V_ZERO) begin
      errors++; $display("FAIL rstmw_idle: got %b expected %b", ctl_vec(), V_ZERO);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ctl_vec() !== V_FETCH_W || bus.instr_retired !== exp_cnt) begin
      errors++; $display("FAIL rstmw_fetch: got %b cnt=%0d expected %b cnt=0",
                         ctl_vec(), bus.instr_retired, V_FETCH_W);
    end
    bus.mem_ready = 1'b1;
    $display("reset in S_MEMWR: write aborted, retired=%0d", bus.instr_retired);
  endtask

  task automatic test_illegal;
    bus.OP = 7'b1101111; bus.Funct3 = 3'b000; bus.Funct7 = 7'd0; bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (ctl_vec() !== V_FETCH_R || bus.illegal !== 1'b0) begin
      errors++; $display("FAIL ill_fetch: got %b ill=%b expected %b ill=0", ctl_vec(), bus.illegal, V_FETCH_R);
    end
    @(negedge clk);
    #1;
    checks++;
    if (ctl_vec() !== V_DECODE || bus.illegal !== 1'b0) begin
      errors++; $display("FAIL ill_decode: got %b ill=%b expected %b ill=0", ctl_vec(), bus.illegal, V_DECODE);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ctl_vec() !== V_ZERO || bus.illegal !== 1'b1 || bus.instr_retired !== exp_cnt) begin
        errors++; $display("FAIL ill_halt%0d: got %b ill=%b cnt=%0d expected %b ill=1 cnt=%0d",
                           i, ctl_vec(), bus.illegal, bus.instr_retired, V_ZERO, exp_cnt);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.illegal !== 1'b0) begin
      errors++; $display("FAIL ill_clear: got %b expected 0", bus.illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("jal (unsupported): halted, illegal sticky until reset");
  endtask

  // Second instance: mem_ready tied low but ignored, 2-bit counter wraps
  task automatic test_wrap;
    logic [1:0] exp2 = 2'd0;
    bus2.OP = 7'b0110011; bus2.Funct3 = 3'b000; bus2.Funct7 = 7'd0; bus2.mem_ready = 1'b0;
    rst2_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus2.IRWrite !== 1'b1 || bus2.instr_retired !== exp2) begin
        errors++; $display("FAIL wrap_add%0d: got irw=%b cnt=%0d expected irw=1 cnt=%0d",
                           k, bus2.IRWrite, bus2.instr_retired, exp2);
      end
      repeat (3) @(negedge clk);
      exp2++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus2.instr_retired !== 2'd0 || bus2.mem_req !== 1'b1) begin
      errors++; $display("FAIL wrap_zero: got cnt=%0d req=%b expected cnt=0 req=1",
                         bus2.instr_retired, bus2.mem_req);
    end
    $display("wrap: 4 adds on 2-bit counter, retired=%0d", bus2.instr_retired);
  endtask

  initial begin
    test_reset();
    test_rtype(3'b000, 7'b0000000, 3'b000, "add");
    test_rtype(3'b000, 7'b0100000, 3'b001, "sub");
    test_rtype(3'b100, 7'b0000000, 3'b111, "xor");
    test_rtype(3'b010, 7'b0000000, 3'b101, "slt");
    test_itype_ori();
    test_load_wait();
    test_store_wait();
    test_beq(1'b1);
    test_beq(1'b0);
    test_reset_midwrite();
    test_rtype(3'b111, 7'b0000000, 3'b010, "and");
    test_illegal();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
